game_input_conditioner: RTL and testbench
=========================================

# game_input_conditioner

Front end for the binary game FSM. Synchronizes and debounces the four raw board buttons and the eight slide switches. Turns each clean press into exactly one command pulse, held until the game's clock-enable samples it. Generates the game's periodic `CEN` strobe, so every press is seen by the game exactly once regardless of how fast `CEN` runs.

## Interface
- `N_DC`, default 20: debounce counter width; a level must be stable for 2^N_DC cycles to be accepted.
- `CEN_DIV`, default 22: width of the free-running `CEN` divider (≥1); `CEN` period = 2^CEN_DIV cycles.

- `Clk` in 1: single system clock; all logic on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `BtnC` in 1: raw centre button.
- `BtnL` in 1: raw left button.
- `BtnR` in 1: raw right button.
- `BtnD` in 1: raw down button.
- `Sw` in 8: raw slide switches.
- `CEN` out 1: one-cycle clock-enable strobe to the game FSM.
- `Select` out 1: conditioned `BtnC` command.
- `selectLeft` out 1: conditioned `BtnL` command.
- `selectRight` out 1: conditioned `BtnR` command.
- `Quit` out 1: conditioned `BtnD` command.
- `userNumber` out 8: switches after a two-flop synchronizer.

## Operation
- Every raw input passes through a two-flop synchronizer (`s1`, `s2`) before use.
- `CEN` divider:
  - Counter `div` (CEN_DIV bits) increments every cycle and wraps.
  - `CEN` is registered high for exactly one cycle, in the cycle after `div` reaches all-ones.
- Per-button FSM, identical and independent for each of the four buttons. Counter `cnt` is N_DC bits.
  - `IDLE`: if `s2`=1, go to `PRESS_WAIT` with `cnt`←0.
  - `PRESS_WAIT`: if `s2`=0, go to `IDLE`. Else `cnt`++; if `cnt` is all-ones, go to `PEND`.
  - `PEND`: command output = 1. If `CEN`=1 this cycle, go to `HELD`, else stay. This holds even if the button is released while in `PEND`.
  - `HELD`: if `s2`=0, go to `REL_WAIT` with `cnt`←0.
  - `REL_WAIT`: if `s2`=1, go to `HELD`. Else `cnt`++; if `cnt` is all-ones, go to `IDLE`.
- Command output is Moore: 1 exactly while the state is `PEND`.
- Holding a button down produces one command only; auto-repeat is not supported.
- No arbitration between buttons. Simultaneous presses may assert several commands in the same `CEN` cycle; the game treats such combinations as no-ops.
- Bounce shorter than 2^N_DC cycles on press or release produces no command.

## Timing
- Reset values: `CEN`=0, all four commands=0, `userNumber`=0, synchronizers=0, `div`=0, all FSMs in `IDLE`, all `cnt`=0.
- Reset asserted mid-operation: outputs drop immediately (asynchronous). Any pending command is discarded.
- Press latency: if raw=1 is first captured into `s1` at edge k and stays stable, `PEND` is entered at edge k+2+2^N_DC.
- The command stays high until and including the first cycle with `CEN`=1. The state leaves `PEND` at the following edge.
- If `CEN`=1 in the first `PEND` cycle, the command is high for exactly one cycle.
- `userNumber` latency: 2 cycles from switch change.
- Next press is accepted only after the button has been quiet for 2^N_DC cycles (`REL_WAIT` completes).

## Structure
- Shared package `game_input_pkg` holds:
  - Debounce state encoding (`IDLE`, `PRESS_WAIT`, `PEND`, `HELD`, `REL_WAIT`; one-hot, 5 bits).
  - Default values for N_DC and CEN_DIV.
- Sub-module `button_debounce` (ports: `Clk`, `Reset`, `raw`, `CEN`, `cmd`; parameter N_DC) contains the synchronizer, `cnt` and FSM. It is instantiated four times.
- Top level holds the `CEN` divider and the switch synchronizer.

## Test plan
All scenarios use N_DC=2 and CEN_DIV=2 (`CEN` every 4 cycles).
- After reset with all inputs 0 → all outputs 0 for 50 cycles; `CEN` high on cycles 4, 8, 12, …
- `BtnC` clean press at edge 10, held 20 cycles → `Select` rises at edge 16 and falls after the next `CEN`; exactly one pulse.
- `BtnL` toggled every 2 cycles for 20 cycles, then held low → `selectLeft` never asserts.
- `BtnR` pressed 5 cycles then released before `CEN` → `selectRight` stays 1 until a `CEN` cycle, then 0; one command.
- `BtnC` and `BtnD` pressed on the same edge → `Select` and `Quit` high during the same `CEN` cycle.
- `BtnD` press with `Quit` pending, `Reset` pulsed → `Quit`=0 immediately, FSM in `IDLE`; `Sw`=8'hA5 appears on `userNumber` 2 cycles after reset release.

Source files
------------

// File: rtl/game_input_pkg.sv
// Shared definitions for the board input front end: debounce state encoding and default widths.
package game_input_pkg;

  localparam int N_DC_DEFAULT    = 20;
  localparam int CEN_DIV_DEFAULT = 22;

  typedef enum logic [4:0] {
    IDLE       = 5'b00001,
    PRESS_WAIT = 5'b00010,
    PEND       = 5'b00100,
    HELD       = 5'b01000,
    REL_WAIT   = 5'b10000
  } db_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop sync, debounce in both directions, one command per clean press.
// cmd rises 2+2^N_DC cycles after raw is first captured and is held until CEN samples it.
module button_debounce
  import game_input_pkg::*;
#(
  parameter int N_DC = N_DC_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  input  logic CEN,
  output logic cmd
);

  logic            s1;
  logic            s2;
  logic [N_DC-1:0] cnt;
  db_state_t       state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      s1 <= raw;
      s2 <= s1;
      unique case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (&cnt) state <= PEND;
          end
        end
        // Releasing the button here must not cancel the command the game has not yet seen.
        PEND: begin
          if (CEN) state <= HELD;
        end
        HELD: begin
          if (!s2) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end
        end
        REL_WAIT: begin
          if (s2) begin
            state <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
            if (&cnt) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd = (state == PEND);

endmodule

// File: rtl/game_input_conditioner.sv
// Board input front end: four debounced button commands, synchronized switches and the game CEN strobe.
// userNumber lags Sw by 2 cycles; CEN is a one-cycle pulse every 2^CEN_DIV cycles.
module game_input_conditioner
  import game_input_pkg::*;
#(
  parameter int N_DC    = N_DC_DEFAULT,
  parameter int CEN_DIV = CEN_DIV_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnC,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnD,
  input  logic [7:0] Sw,
  output logic       CEN,
  output logic       Select,
  output logic       selectLeft,
  output logic       selectRight,
  output logic       Quit,
  output logic [7:0] userNumber
);

  logic [CEN_DIV-1:0] div;
  logic [7:0]         sw_s1;

  // CEN is registered off the all-ones count, so it lands one cycle after the wrap point.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div        <= '0;
      CEN        <= 1'b0;
      sw_s1      <= '0;
      userNumber <= '0;
    end else begin
      div        <= div + 1'b1;
      CEN        <= &div;
      sw_s1      <= Sw;
      userNumber <= sw_s1;
    end
  end

  button_debounce #(.N_DC(N_DC)) u_btn_c (
    .Clk(Clk), .Reset(Reset), .raw(BtnC), .CEN(CEN), .cmd(Select)
  );
  button_debounce #(.N_DC(N_DC)) u_btn_l (
    .Clk(Clk), .Reset(Reset), .raw(BtnL), .CEN(CEN), .cmd(selectLeft)
  );
  button_debounce #(.N_DC(N_DC)) u_btn_r (
    .Clk(Clk), .Reset(Reset), .raw(BtnR), .CEN(CEN), .cmd(selectRight)
  );
  button_debounce #(.N_DC(N_DC)) u_btn_d (
    .Clk(Clk), .Reset(Reset), .raw(BtnD), .CEN(CEN), .cmd(Quit)
  );

endmodule

// File: tb/tb_game_input_conditioner.sv
// Directed bench for game_input_conditioner with N_DC=2, CEN_DIV=2; pulse scoreboard per command.
module tb_game_input_conditioner;
  import game_input_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       BtnC, BtnL, BtnR, BtnD;
  logic [7:0] Sw;
  logic       CEN, Select, selectLeft, selectRight, Quit;
  logic [7:0] userNumber;

  game_input_conditioner #(.N_DC(2), .CEN_DIV(2)) dut (
    .Clk(Clk), .Reset(Reset), .BtnC(BtnC), .BtnL(BtnL), .BtnR(BtnR), .BtnD(BtnD),
    .Sw(Sw), .CEN(CEN), .Select(Select), .selectLeft(selectLeft),
    .selectRight(selectRight), .Quit(Quit), .userNumber(userNumber)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  // cyc = number of rising edges since reset was last released
  always @(posedge Clk or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Expected command pulse: first high cycle and length; len 0 means cut short by reset.
  typedef struct {
    int rise;
    int len;
  } pulse_t;

  pulse_t q_sel[$];
  pulse_t q_lft[$];
  pulse_t q_rgt[$];
  pulse_t q_quit[$];

  // Command stays high from its rise up to and including the first CEN cycle (multiples of 4).
  function automatic int exp_len(input int rise);
    int c;
    c = rise;
    while (c % 4 != 0) c++;
    return c - rise + 1;
  endfunction

  task automatic push_exp(input int ch, input int rise, input int len);
    pulse_t p;
    p.rise = rise;
    p.len  = len;
    case (ch)
      0: q_sel.push_back(p);
      1: q_lft.push_back(p);
      2: q_rgt.push_back(p);
      default: q_quit.push_back(p);
    endcase
  endtask

  task automatic finish_pulse(input int ch, input int rise_obs, input int len_obs);
    pulse_t e;
    bit     have;
    have = 1'b0;
    e.rise = 0;
    e.len  = 0;
    case (ch)
      0: if (q_sel.size() > 0)  begin e = q_sel.pop_front();  have = 1'b1; end
      1: if (q_lft.size() > 0)  begin e = q_lft.pop_front();  have = 1'b1; end
      2: if (q_rgt.size() > 0)  begin e = q_rgt.pop_front();  have = 1'b1; end
      default: if (q_quit.size() > 0) begin e = q_quit.pop_front(); have = 1'b1; end
    endcase
    compared++;
    assert (have === 1'b1) else begin
      failed++;
      $error("FAIL unexpected_pulse ch=%0d observed rise=%0d len=%0d, required no pulse", ch, rise_obs, len_obs);
    end
    if (have) begin
      compared++;
      assert (rise_obs === e.rise) else begin
        failed++;
        $error("FAIL pulse_rise ch=%0d observed=%0d expected=%0d", ch, rise_obs, e.rise);
      end
      compared++;
      assert (len_obs === e.len) else begin
        failed++;
        $error("FAIL pulse_len ch=%0d observed=%0d expected=%0d", ch, len_obs, e.len);
      end
    end
  endtask

  // Monitor: CEN cadence every cycle, and pulse boundaries on the four commands.
  int       rise_at[4];
  bit       busy[4];
  logic [3:0] cmds;
  logic       cen_exp;

  always @(negedge Clk) begin
    cen_exp = (!Reset && cyc > 0 && (cyc % 4 == 0));
    compared++;
    assert (CEN === cen_exp) else begin
      failed++;
      $error("FAIL cen_cadence cyc=%0d observed=%b expected=%b", cyc, CEN, cen_exp);
    end
    cmds = {Quit, selectRight, selectLeft, Select};
    for (int c = 0; c < 4; c++) begin
      if (!busy[c] && cmds[c] === 1'b1) begin
        busy[c]    = 1'b1;
        rise_at[c] = cyc;
      end else if (busy[c] && cmds[c] !== 1'b1) begin
        busy[c] = 1'b0;
        finish_pulse(c, rise_at[c], Reset ? 0 : cyc - rise_at[c]);
      end
    end
  end

  task automatic goto(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 2000) begin
      @(negedge Clk);
      guard++;
    end
    compared++;
    assert (cyc === k) else begin
      failed++;
      $error("FAIL goto observed cyc=%0d expected=%0d", cyc, k);
    end
  endtask

  initial begin
    Reset = 1'b1;
    BtnC = 1'b0; BtnL = 1'b0; BtnR = 1'b0; BtnD = 1'b0;
    Sw = 8'h00;
    for (int c = 0; c < 4; c++) begin
      busy[c] = 1'b0;
      rise_at[c] = 0;
    end
    #12;
    compared++;
    assert ({CEN, Select, selectLeft, selectRight, Quit, userNumber} === 13'h0) else begin
      failed++;
      $error("FAIL reset_outputs observed=%h expected=0", {CEN, Select, selectLeft, selectRight, Quit, userNumber});
    end
    #11 Reset = 1'b0;

    // Quiet inputs: every command and userNumber stay 0.
    for (int i = 1; i <= 50; i++) begin
      goto(i);
      compared++;
      assert ({Select, selectLeft, selectRight, Quit, userNumber} === 12'h0) else begin
        failed++;
        $error("FAIL idle_outputs cyc=%0d observed=%h expected=0", i, {Select, selectLeft, selectRight, Quit, userNumber});
      end
    end

    // Clean BtnC press captured at edge 62: PEND at 68, which is a CEN cycle -> 1-cycle pulse.
    goto(61); BtnC = 1'b1; push_exp(0, 68, exp_len(68));
    goto(81); BtnC = 1'b0;

    // BtnL chatter with 2-cycle highs: never stable long enough.
    goto(99);
    for (int i = 0; i < 10; i++) begin
      BtnL = ~BtnL;
      repeat (2) @(negedge Clk);
    end
    BtnL = 1'b0;

    // BtnR high 5 cycles, released before CEN: command still held until edge 140.
    goto(130); BtnR = 1'b1; push_exp(2, 137, exp_len(137));
    goto(135); BtnR = 1'b0;

    // Simultaneous BtnC and BtnD: both pending in the same CEN cycle.
    goto(152); BtnC = 1'b1; BtnD = 1'b1;
    push_exp(0, 159, exp_len(159));
    push_exp(3, 159, exp_len(159));
    goto(162); BtnC = 1'b0; BtnD = 1'b0;

    // Switch synchronizer latency.
    goto(170); Sw = 8'h3C;
    goto(171);
    compared++;
    assert (userNumber === 8'h00) else begin
      failed++;
      $error("FAIL sw_lat1 observed=%h expected=00", userNumber);
    end
    goto(172);
    compared++;
    assert (userNumber === 8'h3C) else begin
      failed++;
      $error("FAIL sw_lat2 observed=%h expected=3c", userNumber);
    end

    // BtnR press, then a short release bounce: only one command.
    goto(179); BtnR = 1'b1; push_exp(2, 186, exp_len(186));
    goto(195); BtnR = 1'b0;
    goto(197); BtnR = 1'b1;
    goto(205); BtnR = 1'b0;

    // BtnD pending, then reset: Quit drops at once and the command is discarded.
    goto(222); BtnD = 1'b1; push_exp(3, 229, 0);
    goto(230);
    compared++;
    assert (Quit === 1'b1) else begin
      failed++;
      $error("FAIL quit_pending observed=%b expected=1", Quit);
    end
    #2 Reset = 1'b1; Sw = 8'hA5; BtnD = 1'b0;
    #1;
    compared++;
    assert ({CEN, Select, selectLeft, selectRight, Quit, userNumber} === 13'h0) else begin
      failed++;
      $error("FAIL async_reset_outputs observed=%h expected=0", {CEN, Select, selectLeft, selectRight, Quit, userNumber});
    end
    compared++;
    assert (dut.u_btn_d.state === IDLE) else begin
      failed++;
      $error("FAIL async_reset_state observed=%b expected=%b", dut.u_btn_d.state, IDLE);
    end
    @(negedge Clk);
    @(negedge Clk);
    #3 Reset = 1'b0;
    goto(1);
    compared++;
    assert (userNumber === 8'h00) else begin
      failed++;
      $error("FAIL sw_after_reset1 observed=%h expected=00", userNumber);
    end
    goto(2);
    compared++;
    assert (userNumber === 8'hA5) else begin
      failed++;
      $error("FAIL sw_after_reset2 observed=%h expected=a5", userNumber);
    end
    goto(20);

    // Every expected pulse must have been seen.
    compared++;
    assert ((q_sel.size() + q_lft.size() + q_rgt.size() + q_quit.size()) === 0) else begin
      failed++;
      $error("FAIL missing_pulses observed=%0d/%0d/%0d/%0d expected=0/0/0/0",
             q_sel.size(), q_lft.size(), q_rgt.size(), q_quit.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
